max_arbiter: RTL and testbench
==============================

// Module: max_arbiter
// PURPOSE
//  Shares one max_top reduction pipeline between two requesters: req0 = greedy action
//  select (current state), req1 = Q-update next-state max. Arbitrates per cycle and
//  drives max_top inputs from a registered stage. Tracks each in-flight op with a
//  LAT-deep tag pipe. Returns each max to its owner through a per-requester response FIFO.
// PARAMETERS
//  DATA_WIDTH    16  width of one Q-value (signed, as in max_top)
//  ACTIONS        4  Q-values per request; power of 2, >=2
//  ACTIONS_WIDTH  2  log2(ACTIONS); also max_top latency LAT in cycles
//  RESP_DEPTH     5  entries per response FIFO = credit limit per requester; >=1
// PORTS
//  clk          in   1                  clock, all logic on posedge
//  rst          in   1                  synchronous reset, active-high
//  req_valid    in   2                  bit i: requester i presents a vector
//  req_data     in   2*DATA_WIDTH*ACTIONS  requester i vector at slice i
//  req_ready    out  2                  bit i: vector i accepted this cycle (combinational)
//  resp_valid   out  2                  bit i: FIFO i head valid
//  resp_data    out  2*DATA_WIDTH       FIFO i head max value at slice i
//  resp_ready   in   2                  bit i: requester i pops FIFO i head
//  mx_valid     out  1                  to max_top i_valid (registered)
//  mx_data      out  DATA_WIDTH*ACTIONS to max_top i_data (registered)
//  mx_o_valid   in   1                  from max_top o_valid
//  mx_o_data    in   DATA_WIDTH         from max_top o_data
// BEHAVIOUR
//  - Reset: mx_valid=0, mx_data=0, resp_valid=0, credits=0, tag pipe valid=0, rr_ptr=0.
//    Parent ties max_top rst_n = ~rst. Reset mid-operation drops all in-flight ops and
//    FIFO contents. No response is produced for them.
//  - Eligible i = req_valid[i] && credit[i] < RESP_DEPTH. At most one grant per cycle.
//  - Round robin: if both are eligible, grant rr_ptr. On any grant, rr_ptr <= ~granted id.
//  - A single eligible requester is granted regardless of rr_ptr. req_ready = grant, one-hot or 0.
//  - Grant at cycle T: at T+1, mx_valid=1, mx_data=req_data[i], and tag i enters the tag pipe.
//  - No grant: mx_valid=0, mx_data=0.
//  - Tag pipe: LAT stages, shifts each cycle. Its output aligns with mx_o_valid at T+1+LAT.
//  - mx_o_valid=1: push mx_o_data into FIFO[tag]. resp_valid[i] is registered, so the
//    first response is visible at T+2+LAT (T+4 at defaults), FIFO order = grant order.
//  - Any mx_o_valid that disagrees with tag-pipe valid is ignored (no push).
//  - credit[i]: +1 on grant i, -1 on pop i (resp_valid&resp_ready).
//    Grant and pop in the same cycle: credit unchanged. Credit never exceeds RESP_DEPTH.
//  - Credit covers in-flight plus stored entries, so the FIFO never overflows and a
//    push is never stalled. The max_top pipe has no backpressure.
//  - FIFO: circular, wr/rd pointers wrap at RESP_DEPTH. Push and pop in the same cycle
//    on a full FIFO is legal. Pop on empty is ignored.
//  - Throughput: 1 grant/cycle. One requester alone sustains 1/cycle if it pops immediately.
// CONFIGURATION
//  MAX_ARB_FIXED_PRIO_EN defined: fixed priority, req0 always wins when eligible.
//    rr_ptr is removed, and req1 can starve while req0 is eligible.
//  Undefined (default): round robin as above.
// TESTING
//  1 Reset mid-flight:
//    - Grant req0, then assert rst at T+2 for 1 cycle.
//    - Expected: resp_valid=0 through T+10, credits=0, and the next grant is accepted normally.
//  2 Single op:
//    - req0 vector {4,-3,9,1} at T, resp_ready=1.
//    - Expected: req_ready=01 at T, mx_valid at T+1, resp_valid[0]=1 with 9 at T+4 for
//      1 cycle, resp_valid[1]=0 throughout.
//  3 Contention:
//    - Both valid for 4 cycles, vectors req0 {1,2,3,4}, req1 {8,7,6,5}.
//    - Expected: grants 0,1,0,1; FIFO0 yields 4,4 and FIFO1 yields 8,8 in order.
//  4 Credit full:
//    - req1 valid, resp_ready[1]=0 for 10 cycles.
//    - Expected: exactly 5 grants, then req_ready[1]=0 and resp_valid[1] held.
//    - Then raise resp_ready[1]: one new grant per pop, no data lost.
//  5 Negative values:
//    - req1 {-8,-2,-5,-16} (DATA_WIDTH 16, signed).
//    - Expected: resp_data slice 1 = -2 (16'hFFFE).
//  6 MAX_ARB_FIXED_PRIO_EN defined, both valid for 6 cycles.
//    - Expected: all 6 grants to req0, req1 granted on the first cycle req0 drops.

Source files
------------

// File: rtl/max_arbiter_if.sv
// rtl/max_arbiter_if.sv - request/response and max_top bundle shared by max_arbiter and its parent
interface max_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ACTIONS    = 4
);
   logic [1:0]                        req_valid;
   logic [2*DATA_WIDTH*ACTIONS-1:0]   req_data;
   logic [1:0]                        req_ready;
   logic [1:0]                        resp_valid;
   logic [2*DATA_WIDTH-1:0]           resp_data;
   logic [1:0]                        resp_ready;
   logic                              mx_valid;
   logic [DATA_WIDTH*ACTIONS-1:0]     mx_data;
   logic                              mx_o_valid;
   logic [DATA_WIDTH-1:0]             mx_o_data;

   modport slave (
      input  req_valid, req_data, resp_ready, mx_o_valid, mx_o_data,
      output req_ready, resp_valid, resp_data, mx_valid, mx_data
   );

   modport master (
      output req_valid, req_data, resp_ready, mx_o_valid, mx_o_data,
      input  req_ready, resp_valid, resp_data, mx_valid, mx_data
   );
endinterface

// File: rtl/max_arbiter.sv
// rtl/max_arbiter.sv - two-requester arbiter sharing one max_top pipe with per-requester response FIFOs
// MAX_ARB_FIXED_PRIO_EN: requester 0 always wins instead of round robin.
module max_arbiter #(
   parameter int DATA_WIDTH    = 16,
   parameter int ACTIONS       = 4,
   parameter int ACTIONS_WIDTH = 2,
   parameter int RESP_DEPTH    = 5
) (
   input  logic         clk,
   input  logic         rst,
   max_arbiter_if.slave bus
);
   localparam int LAT = ACTIONS_WIDTH;
   localparam int VW  = DATA_WIDTH * ACTIONS;
   localparam int CW  = $clog2(RESP_DEPTH + 1);
   localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);
   localparam logic [PW-1:0] PTR_LAST   = PW'(RESP_DEPTH - 1);

   logic [1:0]            elig;
   logic [1:0]            grant;
   logic [1:0]            pop;
   logic [CW-1:0]         credit_q [2];
   logic [CW-1:0]         credit_d [2];
   logic                  mx_valid_q;
   logic                  mx_tag_q;
   logic [VW-1:0]         mx_data_q;
   logic [LAT-1:0]        tp_valid_q;
   logic [LAT-1:0]        tp_tag_q;
   logic                  push;
   logic                  push_id;
   logic [DATA_WIDTH-1:0] mem_q [2][RESP_DEPTH];
   logic [PW-1:0]         wr_q [2];
   logic [PW-1:0]         rd_q [2];
   logic [CW-1:0]         cnt_q [2];
   logic [1:0]            resp_valid_w;
   logic [2*DATA_WIDTH-1:0] resp_data_w;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Credit counts in-flight plus stored entries, so a granted op always has a FIFO slot.
   always_comb begin
      elig = 2'b00;
      for (int i = 0; i < 2; i++) begin
         elig[i] = bus.req_valid[i] && (credit_q[i] < CREDIT_MAX);
      end
   end

`ifdef MAX_ARB_FIXED_PRIO_EN
   always_comb begin
      grant = 2'b00;
      if (elig[0])      grant = 2'b01;
      else if (elig[1]) grant = 2'b10;
   end
`else
   logic rr_q;
   logic rr_d;

   always_comb begin
      grant = 2'b00;
      rr_d  = rr_q;
      if (elig == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
      else               grant = elig;
      if (grant[0])      rr_d = 1'b1;
      else if (grant[1]) rr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
   end
`endif

   always_comb begin
      pop = 2'b00;
      for (int i = 0; i < 2; i++) begin
         pop[i]      = bus.resp_ready[i] && (cnt_q[i] != '0);
         credit_d[i] = credit_q[i];
         if (grant[i] && !pop[i])      credit_d[i] = credit_q[i] + 1'b1;
         else if (!grant[i] && pop[i]) credit_d[i] = credit_q[i] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q[0] <= '0;
         credit_q[1] <= '0;
      end else begin
         credit_q[0] <= credit_d[0];
         credit_q[1] <= credit_d[1];
      end
   end

   // Registered launch stage into max_top; the tag rides alongside the op for LAT cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         mx_valid_q <= 1'b0;
         mx_tag_q   <= 1'b0;
         mx_data_q  <= '0;
         tp_valid_q <= '0;
         tp_tag_q   <= '0;
      end else begin
         mx_valid_q <= |grant;
         mx_tag_q   <= grant[1];
         if (grant[1])      mx_data_q <= bus.req_data[VW +: VW];
         else if (grant[0]) mx_data_q <= bus.req_data[0 +: VW];
         else               mx_data_q <= '0;
         tp_valid_q[0] <= mx_valid_q;
         tp_tag_q[0]   <= mx_tag_q;
         for (int k = 1; k < LAT; k++) begin
            tp_valid_q[k] <= tp_valid_q[k-1];
            tp_tag_q[k]   <= tp_tag_q[k-1];
         end
      end
   end

   assign push    = bus.mx_o_valid && tp_valid_q[LAT-1];
   assign push_id = tp_tag_q[LAT-1];

   always_ff @(posedge clk) begin
      if (push) mem_q[push_id][wr_q[push_id]] <= bus.mx_o_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_q[i]  <= '0;
            rd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push && (push_id == 1'(i))) wr_q[i] <= ptr_inc(wr_q[i]);
            if (pop[i])                     rd_q[i] <= ptr_inc(rd_q[i]);
            if ((push && (push_id == 1'(i))) && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (!(push && (push_id == 1'(i))) && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      resp_valid_w = 2'b00;
      resp_data_w  = '0;
      for (int i = 0; i < 2; i++) begin
         resp_valid_w[i]                        = (cnt_q[i] != '0);
         resp_data_w[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_q[i]];
      end
   end

   assign bus.req_ready  = grant;
   assign bus.mx_valid   = mx_valid_q;
   assign bus.mx_data    = mx_data_q;
   assign bus.resp_valid = resp_valid_w;
   assign bus.resp_data  = resp_data_w;
endmodule

// File: tb/tb_max_arbiter.sv
// tb/tb_max_arbiter.sv - directed scenarios plus randomized run against a queue-based reference model
module tb_max_arbiter;
   localparam int DW  = 16;
   localparam int A   = 4;
   localparam int VW  = DW * A;
   localparam int D   = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   max_arbiter_if #(.DATA_WIDTH(DW), .ACTIONS(A)) bus ();

   max_arbiter #(.DATA_WIDTH(DW), .ACTIONS(A), .ACTIONS_WIDTH(2), .RESP_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [DW-1:0] vmax(input logic [VW-1:0] v);
      logic signed [DW-1:0] m;
      m = v[DW-1:0];
      for (int k = 1; k < A; k++) if ($signed(v[k*DW +: DW]) > m) m = v[k*DW +: DW];
      return m;
   endfunction

   function automatic logic [VW-1:0] vec4(input int a, input int b, input int c, input int d);
      logic [VW-1:0] v;
      v[0*DW +: DW] = DW'(a);
      v[1*DW +: DW] = DW'(b);
      v[2*DW +: DW] = DW'(c);
      v[3*DW +: DW] = DW'(d);
      return v;
   endfunction

   // Behavioural max_top: two-cycle latency signed max, reset with the parent.
   logic [1:0]    mt_v;
   logic [DW-1:0] mt_d0, mt_d1;
   always @(posedge clk) begin
      if (rst) mt_v <= 2'b00;
      else begin
         mt_v  <= {mt_v[0], bus.mx_valid};
         mt_d0 <= vmax(bus.mx_data);
         mt_d1 <= mt_d0;
      end
   end
   assign bus.mx_o_valid = mt_v[1];
   assign bus.mx_o_data  = mt_d1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid  = 2'b00;
      bus.req_data   = '0;
      bus.resp_ready = 2'b00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", bus.resp_valid); end
      checks++; if (bus.mx_valid !== 1'b0) begin errors++; $display("FAIL reset_mx_valid got %b exp 0", bus.mx_valid); end
      checks++; if (bus.mx_data !== '0) begin errors++; $display("FAIL reset_mx_data got %h exp 0", bus.mx_data); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
      tick();
   endtask

   task automatic test_reset_midflight();
      int q[$];
      int exp_v;
      do_reset();
      bus.resp_ready = 2'b11;
      bus.req_data[0 +: VW] = vec4(5, 6, 7, 8);
      bus.req_valid = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL midflight_grant got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 3; c <= 10; c++) begin
         #1;
         checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL midflight_no_resp c=%0d got %b exp 00", c, bus.resp_valid); end
         tick();
      end
      // Credits must be back to zero: a full RESP_DEPTH worth of grants is accepted.
      bus.resp_ready = 2'b00;
      for (int c = 0; c < 6; c++) begin
         bus.req_data[0 +: VW] = vec4(c, c + 100, 0, -c);
         bus.req_valid = 2'b01;
         #1;
         checks++;
         if (bus.req_ready !== ((c < D) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL midflight_credit c=%0d got %b exp %b", c, bus.req_ready, (c < D) ? 2'b01 : 2'b00);
         end
         if (bus.req_ready[0]) q.push_back(c + 100);
         tick();
      end
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b01;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.resp_valid[0]) begin
            exp_v = (q.size() > 0) ? q.pop_front() : -1;
            checks++; if (bus.resp_data[0 +: DW] !== DW'(exp_v)) begin errors++; $display("FAIL midflight_data got %0d exp %0d", bus.resp_data[0 +: DW], exp_v); end
         end
         tick();
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL midflight_drain got %0d left exp 0", q.size()); end
   endtask

   task automatic test_single_op();
      do_reset();
      bus.resp_ready = 2'b11;
      bus.req_data[0 +: VW] = vec4(4, -3, 9, 1);
      bus.req_valid = 2'b01;
      #1;
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b exp 01", bus.req_ready); end
      tick();
      bus.req_valid = 2'b00;
      for (int c = 1; c <= 7; c++) begin
         #1;
         if (c == 1) begin
            checks++; if (bus.mx_valid !== 1'b1 || bus.mx_data !== vec4(4, -3, 9, 1)) begin
               errors++; $display("FAIL single_mx got v=%b d=%h exp v=1 d=%h", bus.mx_valid, bus.mx_data, vec4(4, -3, 9, 1));
            end
         end
         if (c == 4) begin
            checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data[0 +: DW] !== 16'd9) begin
               errors++; $display("FAIL single_resp got v=%b d=%0d exp v=01 d=9", bus.resp_valid, bus.resp_data[0 +: DW]);
            end
         end else begin
            checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL single_idle c=%0d got %b exp 00", c, bus.resp_valid); end
         end
         tick();
      end
   endtask

   task automatic test_contention();
      int got0[$];
      int got1[$];
      logic [1:0] eg;
      int n0, n1;
`ifdef MAX_ARB_FIXED_PRIO_EN
      n0 = 4; n1 = 0;
`else
      n0 = 2; n1 = 2;
`endif
      do_reset();
      bus.resp_ready = 2'b11;
      bus.req_data[0 +: VW]  = vec4(1, 2, 3, 4);
      bus.req_data[VW +: VW] = vec4(8, 7, 6, 5);
      for (int c = 0; c < 16; c++) begin
         bus.req_valid = (c < 4) ? 2'b11 : 2'b00;
         #1;
         if (c < 4) begin
`ifdef MAX_ARB_FIXED_PRIO_EN
            eg = 2'b01;
`else
            eg = (c % 2 == 1) ? 2'b10 : 2'b01;
`endif
            checks++; if (bus.req_ready !== eg) begin errors++; $display("FAIL contention_grant c=%0d got %b exp %b", c, bus.req_ready, eg); end
         end
         if (bus.resp_valid[0]) got0.push_back(int'(bus.resp_data[0 +: DW]));
         if (bus.resp_valid[1]) got1.push_back(int'(bus.resp_data[DW +: DW]));
         tick();
      end
      checks++; if (got0.size() != n0) begin errors++; $display("FAIL contention_count0 got %0d exp %0d", got0.size(), n0); end
      checks++; if (got1.size() != n1) begin errors++; $display("FAIL contention_count1 got %0d exp %0d", got1.size(), n1); end
      foreach (got0[k]) begin
         checks++; if (got0[k] != 4) begin errors++; $display("FAIL contention_data0 got %0d exp 4", got0[k]); end
      end
      foreach (got1[k]) begin
         checks++; if (got1[k] != 8) begin errors++; $display("FAIL contention_data1 got %0d exp 8", got1[k]); end
      end
   endtask

   task automatic test_credit_full();
      int q[$];
      int grants = 0;
      int grants2 = 0;
      int exp_v;
      do_reset();
      bus.resp_ready = 2'b00;
      for (int c = 0; c < 10; c++) begin
         bus.req_data[VW +: VW] = vec4(-100, 200 + c, 0, 1);
         bus.req_valid = 2'b10;
         #1;
         checks++; if (bus.req_ready !== ((c < D) ? 2'b10 : 2'b00)) begin
            errors++; $display("FAIL credit_grant c=%0d got %b exp %b", c, bus.req_ready, (c < D) ? 2'b10 : 2'b00);
         end
         if (bus.req_ready[1]) begin grants++; q.push_back(200 + c); end
         if (c == 9) begin
            checks++; if (bus.resp_valid[1] !== 1'b1 || bus.resp_data[DW +: DW] !== 16'd200) begin
               errors++; $display("FAIL credit_held got v=%b d=%0d exp v=1 d=200", bus.resp_valid[1], bus.resp_data[DW +: DW]);
            end
         end
         tick();
      end
      checks++; if (grants != D) begin errors++; $display("FAIL credit_grants got %0d exp %0d", grants, D); end
      bus.resp_ready = 2'b10;
      for (int c = 0; c < 30; c++) begin
         bus.req_data[VW +: VW] = vec4(300 + c, 0, -7, 2);
         bus.req_valid = (c < 15) ? 2'b10 : 2'b00;
         #1;
         if (c == 0) begin
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL credit_pop_same_cycle got %b exp 00", bus.req_ready); end
         end
         if (bus.resp_valid[1]) begin
            exp_v = (q.size() > 0) ? q.pop_front() : -1;
            checks++; if (bus.resp_data[DW +: DW] !== DW'(exp_v)) begin errors++; $display("FAIL credit_data got %0d exp %0d", bus.resp_data[DW +: DW], exp_v); end
         end
         if (bus.req_ready[1]) begin grants2++; q.push_back(300 + c); end
         tick();
      end
      checks++; if (grants2 != 14) begin errors++; $display("FAIL credit_throughput got %0d exp 14", grants2); end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL credit_drain got %0d left exp 0", q.size()); end
   endtask

   task automatic test_negative();
      bit seen = 0;
      do_reset();
      bus.resp_ready = 2'b10;
      bus.req_data[VW +: VW] = vec4(-8, -2, -5, -16);
      bus.req_valid = 2'b10;
      tick();
      bus.req_valid = 2'b00;
      for (int c = 0; c < 10 && !seen; c++) begin
         #1;
         if (bus.resp_valid[1]) begin
            seen = 1;
            checks++; if (bus.resp_data[DW +: DW] !== 16'hFFFE) begin errors++; $display("FAIL negative_data got %h exp fffe", bus.resp_data[DW +: DW]); end
         end
         tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL negative_timeout got no response exp one"); end
   endtask

   task automatic test_both_then_drop();
      logic [1:0] eg;
      do_reset();
      bus.resp_ready = 2'b11;
      for (int c = 0; c < 8; c++) begin
         bus.req_data[0 +: VW]  = vec4(c, 1, 2, 3);
         bus.req_data[VW +: VW] = vec4(-c, 9, 0, 0);
         bus.req_valid = (c < 6) ? 2'b11 : ((c == 6) ? 2'b10 : 2'b00);
         #1;
`ifdef MAX_ARB_FIXED_PRIO_EN
         eg = (c < 6) ? 2'b01 : ((c == 6) ? 2'b10 : 2'b00);
`else
         eg = (c < 6) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : ((c == 6) ? 2'b10 : 2'b00);
`endif
         checks++; if (bus.req_ready !== eg) begin errors++; $display("FAIL both_drop_grant c=%0d got %b exp %b", c, bus.req_ready, eg); end
         tick();
      end
   endtask

   typedef struct {
      logic [DW-1:0] val;
      int            rdy;
   } ent_t;

   task automatic test_random();
      ent_t mq0[$];
      ent_t mq1[$];
      ent_t e;
      bit   rr = 0;
      logic pmv = 0;
      logic [VW-1:0] pmd = '0;
      logic [1:0] elig, eg, ev;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.req_valid  = 2'($urandom_range(0, 3));
         bus.resp_ready = {($urandom % 4) != 0, ($urandom % 4) != 0};
         for (int k = 0; k < 2 * A; k++) bus.req_data[k*DW +: DW] = DW'($urandom);
         rst = (($urandom % 64) == 0);
         #1;
         elig[0] = bus.req_valid[0] && (mq0.size() < D);
         elig[1] = bus.req_valid[1] && (mq1.size() < D);
`ifdef MAX_ARB_FIXED_PRIO_EN
         eg = elig[0] ? 2'b01 : (elig[1] ? 2'b10 : 2'b00);
`else
         eg = (elig == 2'b11) ? (rr ? 2'b10 : 2'b01) : elig;
`endif
         ev[0] = (mq0.size() > 0) && (mq0[0].rdy <= cyc);
         ev[1] = (mq1.size() > 0) && (mq1[0].rdy <= cyc);
         checks++; if (bus.req_ready !== eg) begin errors++; $display("FAIL rand_req_ready cyc=%0d got %b exp %b", cyc, bus.req_ready, eg); end
         checks++; if (bus.resp_valid !== ev) begin errors++; $display("FAIL rand_resp_valid cyc=%0d got %b exp %b", cyc, bus.resp_valid, ev); end
         if (ev[0]) begin
            checks++; if (bus.resp_data[0 +: DW] !== mq0[0].val) begin errors++; $display("FAIL rand_data0 cyc=%0d got %h exp %h", cyc, bus.resp_data[0 +: DW], mq0[0].val); end
         end
         if (ev[1]) begin
            checks++; if (bus.resp_data[DW +: DW] !== mq1[0].val) begin errors++; $display("FAIL rand_data1 cyc=%0d got %h exp %h", cyc, bus.resp_data[DW +: DW], mq1[0].val); end
         end
         checks++; if (bus.mx_valid !== pmv || bus.mx_data !== pmd) begin
            errors++; $display("FAIL rand_mx cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, bus.mx_valid, bus.mx_data, pmv, pmd);
         end
         if (rst) begin
            mq0.delete(); mq1.delete();
            rr = 0; pmv = 0; pmd = '0;
         end else begin
            if (ev[0] && bus.resp_ready[0]) void'(mq0.pop_front());
            if (ev[1] && bus.resp_ready[1]) void'(mq1.pop_front());
            if (eg[0]) begin e.val = vmax(bus.req_data[0 +: VW]);  e.rdy = cyc + 4; mq0.push_back(e); rr = 1; end
            if (eg[1]) begin e.val = vmax(bus.req_data[VW +: VW]); e.rdy = cyc + 4; mq1.push_back(e); rr = 0; end
            pmv = |eg;
            pmd = eg[0] ? bus.req_data[0 +: VW] : (eg[1] ? bus.req_data[VW +: VW] : '0);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid  = 2'b00;
      bus.req_data   = '0;
      bus.resp_ready = 2'b00;
      test_reset();
      test_reset_midflight();
      test_single_op();
      test_contention();
      test_credit_full();
      test_negative();
      test_both_then_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
